ln_seq_ctrl: RTL and testbench

//  Sequences the LayerNorm/RMSNorm datapath over a Win x Hin x CHin feature map stored in Tout-channel surfaces.
//  Per pixel it runs two passes:
//   - stats pass: reads all CHin/Tout surfaces into the statistics engine and waits for mean/var ready.
//   - normalize pass: per surface, fetches LN weight/bias, re-reads the data word, issues the output write.

---
 rtl/ln_pkg.sv | 31 +++
 rtl/ln_addr_gen.sv | 138 +++++++++++++
 rtl/ln_seq_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ln_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_pkg.sv
// ln_pkg: shared types and defaults for the LayerNorm/RMSNorm sequencer.
//   - rd_kind_e  : tag on each read command (stat data, weight, norm data)
//   - ln_state_e : sequencer FSM states
//   - LN_* localparams : default widths and byte strides
package ln_pkg;

    localparam int LN_AW        = 32;
    localparam int LN_DIM_W     = 16;
    localparam int LN_CHD_W     = 12;
    localparam int LN_PIX_BYTES = 64;
    localparam int LN_WT_STRIDE = 64;

    typedef enum logic [1:0] {
        RK_STAT = 2'd0,
        RK_WT   = 2'd1,
        RK_NORM = 2'd2
    } rd_kind_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLR       = 4'd1,
        ST_STAT_RD   = 4'd2,
        ST_STAT_WAIT = 4'd3,
        ST_NRM_WT    = 4'd4,
        ST_NRM_DAT   = 4'd5,
        ST_NRM_WR    = 4'd6,
        ST_NEXT      = 4'd7,
        ST_FIN       = 4'd8
    } ln_state_e;

endpackage

// File: rtl/ln_addr_gen.sv
// ln_addr_gen: channel/pixel counters and running address pointers.
// All addresses are built by adding strides to running pointers, so no
// multipliers are needed; every sum wraps modulo 2^AW.
// Ports:
//   clk, rst              clock, async active-high reset
//   i_load                latch bases/strides, zero all counters
//   i_inc_c               advance to the next channel surface
//   i_rst_c               return to surface 0 of the current pixel
//   i_inc_pix             advance to the next pixel (w inner, h outer)
//   i_wrap_w              current pixel is the last one on its line
//   i_*_base/_surf/_line  configuration, sampled on i_load
//   o_c, o_w, o_h         current surface / column / line counters
//   o_din_addr, o_dout_addr, o_wt_addr  addresses for the current (c,w,h)
module ln_addr_gen
    import ln_pkg::*;
#(
    parameter int AW        = LN_AW,
    parameter int DIM_W     = LN_DIM_W,
    parameter int CHD_W     = LN_CHD_W,
    parameter int PIX_BYTES = LN_PIX_BYTES,
    parameter int WT_STRIDE = LN_WT_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_inc_c,
    input  logic             i_rst_c,
    input  logic             i_inc_pix,
    input  logic             i_wrap_w,
    input  logic [AW-1:0]    i_wt_base,
    input  logic [AW-1:0]    i_din_base,
    input  logic [AW-1:0]    i_din_surf,
    input  logic [AW-1:0]    i_din_line,
    input  logic [AW-1:0]    i_dout_base,
    input  logic [AW-1:0]    i_dout_surf,
    input  logic [AW-1:0]    i_dout_line,
    output logic [CHD_W-1:0] o_c,
    output logic [DIM_W-1:0] o_w,
    output logic [DIM_W-1:0] o_h,
    output logic [AW-1:0]    o_din_addr,
    output logic [AW-1:0]    o_dout_addr,
    output logic [AW-1:0]    o_wt_addr
);

    localparam logic [AW-1:0] PIX_STEP = AW'(PIX_BYTES);
    localparam logic [AW-1:0] WT_STEP  = AW'(WT_STRIDE);

    logic [CHD_W-1:0] r_c;
    logic [DIM_W-1:0] r_w, r_h;
    logic [AW-1:0]    r_wt_base, r_din_surf, r_din_line, r_dout_surf, r_dout_line;
    // line_ptr: start of the current line; pix_ptr: current pixel, surface 0;
    // c_ptr: current pixel at surface c.
    logic [AW-1:0]    r_din_line_ptr, r_din_pix_ptr, r_din_c_ptr;
    logic [AW-1:0]    r_dout_line_ptr, r_dout_pix_ptr, r_dout_c_ptr;
    logic [AW-1:0]    r_wt_c_ptr;
    logic [AW-1:0]    w_din_pix_nxt, w_dout_pix_nxt;

    // Next pixel base: a new line restarts from the line pointer plus one line stride.
    always_comb begin
        if (i_wrap_w) begin
            w_din_pix_nxt  = r_din_line_ptr + r_din_line;
            w_dout_pix_nxt = r_dout_line_ptr + r_dout_line;
        end else begin
            w_din_pix_nxt  = r_din_pix_ptr + PIX_STEP;
            w_dout_pix_nxt = r_dout_pix_ptr + PIX_STEP;
        end
    end

    // Counter and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c             <= '0;
            r_w             <= '0;
            r_h             <= '0;
            r_wt_base       <= '0;
            r_din_surf      <= '0;
            r_din_line      <= '0;
            r_dout_surf     <= '0;
            r_dout_line     <= '0;
            r_din_line_ptr  <= '0;
            r_din_pix_ptr   <= '0;
            r_din_c_ptr     <= '0;
            r_dout_line_ptr <= '0;
            r_dout_pix_ptr  <= '0;
            r_dout_c_ptr    <= '0;
            r_wt_c_ptr      <= '0;
        end else if (i_load) begin
            r_c             <= '0;
            r_w             <= '0;
            r_h             <= '0;
            r_wt_base       <= i_wt_base;
            r_din_surf      <= i_din_surf;
            r_din_line      <= i_din_line;
            r_dout_surf     <= i_dout_surf;
            r_dout_line     <= i_dout_line;
            r_din_line_ptr  <= i_din_base;
            r_din_pix_ptr   <= i_din_base;
            r_din_c_ptr     <= i_din_base;
            r_dout_line_ptr <= i_dout_base;
            r_dout_pix_ptr  <= i_dout_base;
            r_dout_c_ptr    <= i_dout_base;
            r_wt_c_ptr      <= i_wt_base;
        end else if (i_inc_pix) begin
            r_c            <= '0;
            r_din_pix_ptr  <= w_din_pix_nxt;
            r_din_c_ptr    <= w_din_pix_nxt;
            r_dout_pix_ptr <= w_dout_pix_nxt;
            r_dout_c_ptr   <= w_dout_pix_nxt;
            r_wt_c_ptr     <= r_wt_base;
            if (i_wrap_w) begin
                r_w             <= '0;
                r_h             <= r_h + DIM_W'(1);
                r_din_line_ptr  <= w_din_pix_nxt;
                r_dout_line_ptr <= w_dout_pix_nxt;
            end else begin
                r_w <= r_w + DIM_W'(1);
            end
        end else if (i_rst_c) begin
            r_c          <= '0;
            r_din_c_ptr  <= r_din_pix_ptr;
            r_dout_c_ptr <= r_dout_pix_ptr;
            r_wt_c_ptr   <= r_wt_base;
        end else if (i_inc_c) begin
            r_c          <= r_c + CHD_W'(1);
            r_din_c_ptr  <= r_din_c_ptr + r_din_surf;
            r_dout_c_ptr <= r_dout_c_ptr + r_dout_surf;
            r_wt_c_ptr   <= r_wt_c_ptr + WT_STEP;
        end
    end

    assign o_c         = r_c;
    assign o_w         = r_w;
    assign o_h         = r_h;
    assign o_din_addr  = r_din_c_ptr;
    assign o_dout_addr = r_dout_c_ptr;
    assign o_wt_addr   = r_wt_c_ptr;

endmodule

// File: rtl/ln_seq_ctrl.sv
// ln_seq_ctrl: two-pass (stats, then normalize) sequencer for the LN unit.
// Per pixel: clear stats, read every surface into the stat engine, wait for
// stat_done, then per surface read weight, re-read data, issue the write.
// Ports:
//   clk, rst                 clock, async active-high reset
//   i_start                  launch pulse, cfg sampled here (ignored while busy)
//   i_cfg_*                  geometry, mode, bases and strides
//   o_rd_valid/i_rd_ready    read command handshake, o_rd_addr/o_rd_kind payload
//   o_stat_clr, i_stat_done  stat engine clear pulse / stats-ready level
//   o_wr_valid/i_wr_ready    write command handshake, o_wr_addr payload
//   o_ln_mode                latched RMSNorm select
//   o_busy, o_done           job in progress / completion pulse
module ln_seq_ctrl
    import ln_pkg::*;
#(
    parameter int AW        = LN_AW,
    parameter int DIM_W     = LN_DIM_W,
    parameter int CHD_W     = LN_CHD_W,
    parameter int PIX_BYTES = LN_PIX_BYTES,
    parameter int WT_STRIDE = LN_WT_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DIM_W-1:0] i_cfg_win,
    input  logic [DIM_W-1:0] i_cfg_hin,
    input  logic [CHD_W-1:0] i_cfg_ch_div_tout,
    input  logic             i_cfg_rms,
    input  logic [AW-1:0]    i_cfg_wt_base,
    input  logic [AW-1:0]    i_cfg_din_base,
    input  logic [AW-1:0]    i_cfg_din_surf,
    input  logic [AW-1:0]    i_cfg_din_line,
    input  logic [AW-1:0]    i_cfg_dout_base,
    input  logic [AW-1:0]    i_cfg_dout_surf,
    input  logic [AW-1:0]    i_cfg_dout_line,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic [AW-1:0]    o_rd_addr,
    output logic [1:0]       o_rd_kind,
    output logic             o_stat_clr,
    input  logic             i_stat_done,
    output logic             o_wr_valid,
    input  logic             i_wr_ready,
    output logic [AW-1:0]    o_wr_addr,
    output logic             o_ln_mode,
    output logic             o_busy,
    output logic             o_done
);

    ln_state_e        r_state;
    logic [DIM_W-1:0] r_win, r_hin;
    logic [CHD_W-1:0] r_ch;
    logic             r_rd_valid, r_stat_clr, r_wr_valid, r_ln_mode, r_busy, r_done;
    logic [AW-1:0]    r_rd_addr, r_wr_addr;
    rd_kind_e         r_rd_kind;

    logic [CHD_W-1:0] w_c;
    logic [DIM_W-1:0] w_w, w_h;
    logic [AW-1:0]    w_din_addr, w_dout_addr, w_wt_addr;
    logic             w_rd_fire, w_wr_fire, w_last_c, w_wrap_w, w_last_h, w_zero_cfg;
    logic             w_load, w_inc_c, w_rst_c, w_inc_pix;

    assign w_rd_fire  = r_rd_valid & i_rd_ready;
    assign w_wr_fire  = r_wr_valid & i_wr_ready;
    assign w_last_c   = (w_c == (r_ch - CHD_W'(1)));
    assign w_wrap_w   = (w_w == (r_win - DIM_W'(1)));
    assign w_last_h   = (w_h == (r_hin - DIM_W'(1)));
    assign w_zero_cfg = (i_cfg_win == '0) | (i_cfg_hin == '0) | (i_cfg_ch_div_tout == '0);

    // Step commands for the address generator, decoded from state and handshakes.
    always_comb begin
        w_load    = 1'b0;
        w_inc_c   = 1'b0;
        w_rst_c   = 1'b0;
        w_inc_pix = 1'b0;
        case (r_state)
            ST_IDLE:    w_load = i_start;
            ST_STAT_RD: begin
                if (w_rd_fire) begin
                    w_rst_c = w_last_c;
                    w_inc_c = ~w_last_c;
                end else begin
                    w_inc_c = 1'b0;
                end
            end
            ST_NRM_WR:  w_inc_c = w_wr_fire & ~w_last_c;
            ST_NEXT:    w_inc_pix = 1'b1;
            default:    w_load = 1'b0;
        endcase
    end

    ln_addr_gen #(
        .AW        (AW),
        .DIM_W     (DIM_W),
        .CHD_W     (CHD_W),
        .PIX_BYTES (PIX_BYTES),
        .WT_STRIDE (WT_STRIDE)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_inc_c     (w_inc_c),
        .i_rst_c     (w_rst_c),
        .i_inc_pix   (w_inc_pix),
        .i_wrap_w    (w_wrap_w),
        .i_wt_base   (i_cfg_wt_base),
        .i_din_base  (i_cfg_din_base),
        .i_din_surf  (i_cfg_din_surf),
        .i_din_line  (i_cfg_din_line),
        .i_dout_base (i_cfg_dout_base),
        .i_dout_surf (i_cfg_dout_surf),
        .i_dout_line (i_cfg_dout_line),
        .o_c         (w_c),
        .o_w         (w_w),
        .o_h         (w_h),
        .o_din_addr  (w_din_addr),
        .o_dout_addr (w_dout_addr),
        .o_wt_addr   (w_wt_addr)
    );

    // Sequencer FSM with registered command outputs. After a handshake that
    // steps the surface counter, valid drops for one cycle so the next
    // command is loaded from the already-updated pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_win      <= '0;
            r_hin      <= '0;
            r_ch       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_kind  <= RK_STAT;
            r_stat_clr <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_ln_mode  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_win     <= i_cfg_win;
                        r_hin     <= i_cfg_hin;
                        r_ch      <= i_cfg_ch_div_tout;
                        r_ln_mode <= i_cfg_rms;
                        r_busy    <= 1'b1;
                        if (w_zero_cfg) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_stat_clr <= 1'b1;
                            r_state    <= ST_CLR;
                        end
                    end
                end
                ST_CLR: begin
                    r_stat_clr <= 1'b0;
                    r_rd_valid <= 1'b1;
                    r_rd_kind  <= RK_STAT;
                    r_rd_addr  <= w_din_addr;
                    r_state    <= ST_STAT_RD;
                end
                ST_STAT_RD: begin
                    if (!r_rd_valid) begin
                        r_rd_valid <= 1'b1;
                        r_rd_addr  <= w_din_addr;
                    end else if (i_rd_ready) begin
                        r_rd_valid <= 1'b0;
                        if (w_last_c) begin
                            r_state <= ST_STAT_WAIT;
                        end
                    end
                end
                ST_STAT_WAIT: begin
                    if (i_stat_done) begin
                        r_rd_valid <= 1'b1;
                        r_rd_kind  <= RK_WT;
                        r_rd_addr  <= w_wt_addr;
                        r_state    <= ST_NRM_WT;
                    end
                end
                ST_NRM_WT: begin
                    if (!r_rd_valid) begin
                        r_rd_valid <= 1'b1;
                        r_rd_kind  <= RK_WT;
                        r_rd_addr  <= w_wt_addr;
                    end else if (i_rd_ready) begin
                        r_rd_kind <= RK_NORM;
                        r_rd_addr <= w_din_addr;
                        r_state   <= ST_NRM_DAT;
                    end
                end
                ST_NRM_DAT: begin
                    if (w_rd_fire) begin
                        r_rd_valid <= 1'b0;
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= w_dout_addr;
                        r_state    <= ST_NRM_WR;
                    end
                end
                ST_NRM_WR: begin
                    if (w_wr_fire) begin
                        r_wr_valid <= 1'b0;
                        r_state    <= w_last_c ? ST_NEXT : ST_NRM_WT;
                    end
                end
                ST_NEXT: begin
                    if (w_wrap_w && w_last_h) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_stat_clr <= 1'b1;
                        r_state    <= ST_CLR;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_addr  = r_rd_addr;
    assign o_rd_kind  = r_rd_kind;
    assign o_stat_clr = r_stat_clr;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_ln_mode  = r_ln_mode;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_ln_seq_ctrl.sv
// Self-checking bench for ln_seq_ctrl. Expected command streams come from a
// nested-loop model over (h, w, c) using plain multiplication.
module tb_ln_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, cfg_rms;
    logic [15:0] cfg_win, cfg_hin;
    logic [11:0] cfg_ch;
    logic [31:0] cfg_wt_base, cfg_din_base, cfg_din_surf, cfg_din_line;
    logic [31:0] cfg_dout_base, cfg_dout_surf, cfg_dout_line;
    logic        rd_valid, rd_ready, stat_clr, stat_done, wr_valid, wr_ready;
    logic        ln_mode, busy, done;
    logic [31:0] rd_addr, wr_addr;
    logic [1:0]  rd_kind;

    typedef struct packed {
        logic        wr;
        logic [1:0]  kind;
        logic [31:0] addr;
    } cmd_t;

    cmd_t q_obs[$];
    cmd_t q_exp[$];
    int   total = 0;
    int   bad   = 0;
    int   n_clr, n_done, n_busy, n_valid, n_stat;
    int   job_ch = 0;
    bit   stall_en = 1'b0;

    ln_seq_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (start),
        .i_cfg_win         (cfg_win),
        .i_cfg_hin         (cfg_hin),
        .i_cfg_ch_div_tout (cfg_ch),
        .i_cfg_rms         (cfg_rms),
        .i_cfg_wt_base     (cfg_wt_base),
        .i_cfg_din_base    (cfg_din_base),
        .i_cfg_din_surf    (cfg_din_surf),
        .i_cfg_din_line    (cfg_din_line),
        .i_cfg_dout_base   (cfg_dout_base),
        .i_cfg_dout_surf   (cfg_dout_surf),
        .i_cfg_dout_line   (cfg_dout_line),
        .o_rd_valid        (rd_valid),
        .i_rd_ready        (rd_ready),
        .o_rd_addr         (rd_addr),
        .o_rd_kind         (rd_kind),
        .o_stat_clr        (stat_clr),
        .i_stat_done       (stat_done),
        .o_wr_valid        (wr_valid),
        .i_wr_ready        (wr_ready),
        .o_wr_addr         (wr_addr),
        .o_ln_mode         (ln_mode),
        .o_busy            (busy),
        .o_done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t get_obs(input int i);
        if (i < q_obs.size()) return q_obs[i];
        return '0;
    endfunction

    // Monitor: records handshakes, pulse counts and hold-during-stall at negedge.
    initial begin
        bit          p_rd_stall = 1'b0, p_wr_stall = 1'b0;
        logic [1:0]  p_rd_kind  = 2'd0;
        logic [31:0] p_rd_addr  = 32'd0, p_wr_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_rd_stall = 1'b0;
                p_wr_stall = 1'b0;
            end else begin
                if (p_rd_stall) chk("rd_hold", 64'({rd_valid, rd_kind, rd_addr}), 64'({1'b1, p_rd_kind, p_rd_addr}));
                if (p_wr_stall) chk("wr_hold", 64'({wr_valid, wr_addr}), 64'({1'b1, p_wr_addr}));
                p_rd_stall = rd_valid && !rd_ready;
                p_rd_kind  = rd_kind;
                p_rd_addr  = rd_addr;
                p_wr_stall = wr_valid && !wr_ready;
                p_wr_addr  = wr_addr;
                if (rd_valid && rd_ready) begin
                    q_obs.push_back({1'b0, rd_kind, rd_addr});
                    if (rd_kind == 2'd0) n_stat++;
                end
                if (wr_valid && wr_ready) q_obs.push_back({1'b1, 2'd0, wr_addr});
                if (stat_clr) begin
                    n_clr++;
                    n_stat = 0;
                end
                if (done) n_done++;
                if (busy) n_busy++;
                if (rd_valid || wr_valid) n_valid++;
            end
        end
    end

    // Command-queue ready drivers (30% low when stalls are enabled).
    initial begin
        rd_ready = 1'b1;
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
            wr_ready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // Stat engine: stats ready a random 0..3 cycles after all surfaces of a pixel were read.
    initial begin
        int dly = 0;
        stat_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stat_clr) begin
                stat_done = 1'b0;
                dly = $urandom_range(0, 3);
            end else if (!stat_done && job_ch != 0 && n_stat == job_ch) begin
                if (dly == 0) stat_done = 1'b1;
                else dly--;
            end
        end
    end

    task automatic set_cfg(input int win, input int hin, input int ch, input bit rms,
                           input logic [31:0] wt, input logic [31:0] din, input logic [31:0] dsurf,
                           input logic [31:0] dline, input logic [31:0] dout, input logic [31:0] osurf,
                           input logic [31:0] oline);
        cfg_win       = 16'(win);
        cfg_hin       = 16'(hin);
        cfg_ch        = 12'(ch);
        cfg_rms       = rms;
        cfg_wt_base   = wt;
        cfg_din_base  = din;
        cfg_din_surf  = dsurf;
        cfg_din_line  = dline;
        cfg_dout_base = dout;
        cfg_dout_surf = osurf;
        cfg_dout_line = oline;
    endtask

    // Reference model: expected command stream from the current cfg.
    task automatic prep_job();
        logic [31:0] da;
        q_exp.delete();
        for (int h = 0; h < int'(cfg_hin); h++) begin
            for (int w = 0; w < int'(cfg_win); w++) begin
                for (int c = 0; c < int'(cfg_ch); c++) begin
                    da = cfg_din_base + 32'(c) * cfg_din_surf + 32'(h) * cfg_din_line + 32'(w) * 32'd64;
                    q_exp.push_back({1'b0, 2'd0, da});
                end
                for (int c = 0; c < int'(cfg_ch); c++) begin
                    da = cfg_din_base + 32'(c) * cfg_din_surf + 32'(h) * cfg_din_line + 32'(w) * 32'd64;
                    q_exp.push_back({1'b0, 2'd1, cfg_wt_base + 32'(c) * 32'd64});
                    q_exp.push_back({1'b0, 2'd2, da});
                    q_exp.push_back({1'b1, 2'd0, cfg_dout_base + 32'(c) * cfg_dout_surf
                                                 + 32'(h) * cfg_dout_line + 32'(w) * 32'd64});
                end
            end
        end
        job_ch = int'(cfg_ch);
        q_obs.delete();
        n_clr = 0; n_done = 0; n_busy = 0; n_valid = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int exp_pix);
        int k = 0;
        while (n_done == 0 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_ncmd"}, 64'(q_obs.size()), 64'(q_exp.size()));
        for (int i = 0; i < q_exp.size(); i++) chk({tag, "_cmd"}, 64'(get_obs(i)), 64'(q_exp[i]));
        chk({tag, "_nclr"}, 64'(n_clr), 64'(exp_pix));
        chk({tag, "_ndone"}, 64'(n_done), 64'd1);
        chk({tag, "_idle"}, 64'({busy, rd_valid, wr_valid}), 64'd0);
    endtask

    initial begin
        cmd_t t;
        int   k;
        rst = 1'b1; start = 1'b0;
        set_cfg(0, 0, 0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 64'({rd_valid, wr_valid, stat_clr, busy, done, ln_mode, rd_kind}), 64'd0);
        chk("reset_addr", 64'({rd_addr, wr_addr}), 64'd0);
        rst = 1'b0;

        // 1: single pixel, 4 surfaces, latency and fixed addresses
        set_cfg(1, 1, 4, 1'b1, 32'h0100_0000, 32'd0, 32'd64, 32'd0, 32'h0800_0000, 32'd64, 32'd0);
        prep_job();
        pulse_start();
        chk("t1_lat1", 64'({stat_clr, busy, rd_valid}), 64'b110);
        @(posedge clk); #1;
        chk("t1_lat2", 64'({stat_clr, rd_valid, rd_kind, rd_addr}), 64'({1'b0, 1'b1, 2'd0, 32'd0}));
        chk("t1_mode", 64'(ln_mode), 64'd1);
        finish_job("t1", 1);
        chk("t1_hs16", 64'(q_obs.size()), 64'd16);
        t = get_obs(3);
        chk("t1_stat3", 64'(t.addr), 64'd192);
        t = get_obs(4);
        chk("t1_wt0", 64'({t.kind, t.addr}), 64'({2'd1, 32'h0100_0000}));
        t = get_obs(15);
        chk("t1_wr3", 64'({t.wr, t.addr}), 64'({1'b1, 32'h0800_00C0}));

        // 2: 3x2 pixels, 2 surfaces, line stride 192
        set_cfg(3, 2, 2, 1'b0, 32'h300, 32'd0, 32'h1000, 32'd192, 32'h2000_0000, 32'h100, 32'h4000);
        prep_job();
        pulse_start();
        finish_job("t2", 6);
        for (int p = 0; p < 6; p++) begin
            t = get_obs(p * 8);
            chk("t2_pixbase", 64'(t.addr), 64'(p * 64));
        end

        // 3: same job under random ready stalls
        stall_en = 1'b1;
        prep_job();
        pulse_start();
        finish_job("t3", 6);
        stall_en = 1'b0;

        // 4: zero width
        set_cfg(0, 2, 2, 1'b0, 32'd0, 32'd0, 32'd64, 32'd64, 32'd0, 32'd64, 32'd64);
        prep_job();
        pulse_start();
        chk("t4_c1", 64'({busy, done, rd_valid, stat_clr}), 64'b1000);
        @(posedge clk); #1;
        chk("t4_c2", 64'({busy, done}), 64'b01);
        @(posedge clk); #1;
        chk("t4_c3", 64'({busy, done}), 64'b00);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_busy1", 64'(n_busy), 64'd1);
        chk("t4_novalid", 64'(n_valid), 64'd0);
        chk("t4_ndone", 64'(n_done), 64'd1);

        // 5: reset during the norm-data read of pixel 2, then rerun
        set_cfg(3, 1, 2, 1'b1, 32'h500, 32'd0, 32'h1000, 32'd0, 32'h9000, 32'h200, 32'd0);
        prep_job();
        pulse_start();
        k = 0;
        while (!(rd_valid && rd_kind == 2'd2 && rd_addr == 32'd128) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t5_found", 64'(rd_valid && rd_kind == 2'd2 && rd_addr == 32'd128), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_ctl", 64'({rd_valid, wr_valid, stat_clr, busy, done, ln_mode, rd_kind}), 64'd0);
        chk("t5_rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_nodone", 64'(n_done), 64'd0);
        prep_job();
        pulse_start();
        finish_job("t5", 3);

        // 6: start re-pulsed while busy with different cfg
        set_cfg(2, 1, 3, 1'b0, 32'h40, 32'h10_0000, 32'h800, 32'd0, 32'h20_0000, 32'h400, 32'd0);
        prep_job();
        pulse_start();
        repeat (5) @(posedge clk);
        set_cfg(1, 1, 1, 1'b1, 32'hAAAA_0000, 32'hBBBB_0000, 32'd8, 32'd8, 32'hCCCC_0000, 32'd8, 32'd8);
        pulse_start();
        finish_job("t6", 2);
        chk("t6_mode", 64'(ln_mode), 64'd0);

        // Random configurations with wrapping addresses and random stalls
        for (int r = 0; r < 4; r++) begin
            set_cfg($urandom_range(1, 3), $urandom_range(1, 2), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            stall_en = 1'($urandom_range(0, 1));
            prep_job();
            pulse_start();
            finish_job("rnd", int'(cfg_win) * int'(cfg_hin));
            chk("rnd_mode", 64'(ln_mode), 64'(cfg_rms));
        end
        stall_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
